// File: rtl/led_matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_matrix_pkg
// Purpose  : Shared constants, scan-state encoding and image slicing helper
//            for the 5x7 LED matrix column scanner.
// Revision : 1.0 - initial release
// ============================================================================
package led_matrix_pkg;

  // Physical matrix geometry
  localparam int MATRIX_COLS = 5;
  localparam int MATRIX_ROWS = 7;

  // Scan sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  // Bit offset of column `col` inside a flattened image of `rows`-bit columns
  function automatic int col_offset(input int col, input int rows);
    return col * rows;
  endfunction

  // Largest of three integers; used to size the shared duration counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_matrix_tick_counter.sv
`default_nettype none
// ============================================================================
// Module   : led_matrix_tick_counter
// Purpose  : Loadable down-counter. tc is high while the count is zero, so a
//            load of N-1 yields a terminal count after exactly N cycles.
// Revision : 1.0 - initial release
// ============================================================================
module led_matrix_tick_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // Load takes priority; otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule
`default_nettype wire

// File: rtl/led_matrix_column_scanner.sv
`default_nettype none
// ============================================================================
// Module   : led_matrix_column_scanner
// Purpose  : Time-multiplexed 5x7 LED matrix driver. Snapshots the image at
//            each frame start, then lights one column at a time with optional
//            all-off blanking before each column.
// Revision : 1.0 - initial release
// ============================================================================
module led_matrix_column_scanner
  import led_matrix_pkg::*;
#(
  parameter int NUM_COLS       = MATRIX_COLS,
  parameter int NUM_ROWS       = MATRIX_ROWS,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter bit COL_ACTIVE_LOW = 1'b1,
  parameter bit ROW_ACTIVE_LOW = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_COLS*NUM_ROWS-1:0] image_in,
  output logic [NUM_COLS-1:0]          col_sel,
  output logic [NUM_ROWS-1:0]          row_out,
  output logic                         frame_done
);

  localparam int CNT_SPAN = max3(SCAN_DIV, BLANK_CYCLES, 1);
  localparam int CNT_W    = (CNT_SPAN > 1) ? $clog2(CNT_SPAN) : 1;
  localparam int COL_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  // Counter reload values: a load of N-1 gives an N-cycle dwell
  localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(NUM_COLS - 1);

  localparam logic [NUM_COLS-1:0] COL_IDLE = {NUM_COLS{COL_ACTIVE_LOW}};
  localparam logic [NUM_ROWS-1:0] ROW_IDLE = {NUM_ROWS{ROW_ACTIVE_LOW}};

  scan_state_t                  state;
  scan_state_t                  state_nxt;
  logic [COL_W-1:0]             col_idx;
  logic [COL_W-1:0]             col_nxt;
  logic [NUM_COLS*NUM_ROWS-1:0] frame_buf;
  logic [NUM_COLS*NUM_ROWS-1:0] img_nxt;
  logic                         snap;
  logic                         cnt_load;
  logic [CNT_W-1:0]             cnt_load_val;
  logic                         cnt_tc;
  logic                         frame_done_nxt;
  logic [NUM_COLS-1:0]          col_onehot;
  logic [NUM_COLS-1:0]          col_sel_nxt;
  logic [NUM_ROWS-1:0]          row_nxt;

  // Shared dwell timer for both BLANK and SHOW periods
  led_matrix_tick_counter #(
    .WIDTH (CNT_W)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .tc       (cnt_tc)
  );

  // Next-state, next-column, snapshot and timer-reload decisions
  always_comb begin
    state_nxt      = state;
    col_nxt        = col_idx;
    snap           = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_val   = '0;
    frame_done_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        if (enable) begin
          snap     = 1'b1;
          col_nxt  = '0;
          cnt_load = 1'b1;
          if (HAS_BLANK) begin
            state_nxt    = ST_BLANK;
            cnt_load_val = BLANK_LOAD;
          end else begin
            state_nxt    = ST_SHOW;
            cnt_load_val = SHOW_LOAD;
          end
        end
      end

      ST_BLANK: begin
        if (cnt_tc) begin
          state_nxt    = ST_SHOW;
          cnt_load     = 1'b1;
          cnt_load_val = SHOW_LOAD;
        end
      end

      ST_SHOW: begin
        if (cnt_tc) begin
          cnt_load = 1'b1;
          if (col_idx == LAST_COL) begin
            // Frame wrap: restart at column 0 with a fresh image
            col_nxt        = '0;
            snap           = 1'b1;
            frame_done_nxt = 1'b1;
          end else begin
            col_nxt = col_idx + COL_W'(1);
          end
          if (HAS_BLANK) begin
            state_nxt    = ST_BLANK;
            cnt_load_val = BLANK_LOAD;
          end else begin
            state_nxt    = ST_SHOW;
            cnt_load_val = SHOW_LOAD;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Dropping enable wins over everything, including a simultaneous wrap
    if (!enable) begin
      state_nxt      = ST_IDLE;
      col_nxt        = '0;
      snap           = 1'b0;
      frame_done_nxt = 1'b0;
      cnt_load       = 1'b1;
      cnt_load_val   = '0;
    end
  end

  // One-hot decode of the column that will be selected after this edge
  for (genvar g = 0; g < NUM_COLS; g++) begin : g_col_decode
    assign col_onehot[g] = (col_nxt == COL_W'(g));
  end

  // Output values for the coming cycle; rows come from the new snapshot on a
  // frame-start edge so a zero-blank wrap shows the fresh image immediately
  always_comb begin
    img_nxt     = snap ? image_in : frame_buf;
    col_sel_nxt = COL_IDLE;
    row_nxt     = ROW_IDLE;
    if (state_nxt == ST_SHOW) begin
      col_sel_nxt = col_onehot ^ COL_IDLE;
      row_nxt     = img_nxt[col_offset(int'(col_nxt), NUM_ROWS) +: NUM_ROWS] ^ ROW_IDLE;
    end
  end

  // State, frame buffer and registered pin drive
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      col_idx    <= '0;
      frame_buf  <= '0;
      frame_done <= 1'b0;
      col_sel    <= COL_IDLE;
      row_out    <= ROW_IDLE;
    end else begin
      state      <= state_nxt;
      col_idx    <= col_nxt;
      frame_done <= frame_done_nxt;
      col_sel    <= col_sel_nxt;
      row_out    <= row_nxt;
      if (snap) begin
        frame_buf <= image_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_column_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_matrix_column_scanner
// Purpose  : Self-checking bench for led_matrix_column_scanner. Two instances
//            (one blank cycle / active-high rows, and zero blank / active-low
//            rows) are compared each cycle against a frame-position model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_matrix_column_scanner;

  localparam int N = 5;
  localparam int R = 7;
  localparam int S = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic [N*R-1:0] image = '0;

  logic [N-1:0] cs_a, cs_b;
  logic [R-1:0] ro_a, ro_b;
  logic         fd_a, fd_b;

  int total = 0;
  int bad   = 0;

  // Model state per instance: running flag, cycles since frame-0 start, snapshot
  bit           run_m  [2];
  int           k_m    [2];
  logic [N*R-1:0] snap_m [2];

  always #5 clk = ~clk;

  led_matrix_column_scanner #(
    .NUM_COLS(N), .NUM_ROWS(R), .SCAN_DIV(S), .BLANK_CYCLES(1),
    .COL_ACTIVE_LOW(1'b1), .ROW_ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .image_in(image),
    .col_sel(cs_a), .row_out(ro_a), .frame_done(fd_a)
  );

  led_matrix_column_scanner #(
    .NUM_COLS(N), .NUM_ROWS(R), .SCAN_DIV(S), .BLANK_CYCLES(0),
    .COL_ACTIVE_LOW(1'b1), .ROW_ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .image_in(image),
    .col_sel(cs_b), .row_out(ro_b), .frame_done(fd_b)
  );

  function automatic int blank_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  // Reference: frame is N slots of (blank + S show) cycles, counted from the
  // edge that first samples enable=1; image captured at every frame start
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset || !enable) begin
        run_m[d] = 1'b0;
        k_m[d]   = 0;
      end else if (!run_m[d]) begin
        run_m[d]  = 1'b1;
        k_m[d]    = 0;
        snap_m[d] = image;
      end else begin
        k_m[d] = k_m[d] + 1;
        if (k_m[d] % (N * (blank_of(d) + S)) == 0) snap_m[d] = image;
      end
    end
  end

  task automatic check_dut(input int d, input logic [N-1:0] cs,
                           input logic [R-1:0] ro, input logic fd);
    logic [N-1:0]   ecs;
    logic [R-1:0]   ero;
    logic           efd;
    logic [N*R-1:0] img;
    bit             rpol;
    int             p, idx, col, ph;
    rpol = (d == 1);
    ecs  = '1;
    ero  = {R{rpol}};
    efd  = 1'b0;
    if (run_m[d]) begin
      p   = blank_of(d) + S;
      idx = k_m[d] % (N * p);
      col = idx / p;
      ph  = idx % p;
      img = snap_m[d];
      if (ph >= blank_of(d)) begin
        ecs[col] = 1'b0;
        ero      = img[col*R +: R] ^ {R{rpol}};
      end
      efd = (idx == 0) && (k_m[d] > 0);
    end
    total++;
    assert (cs === ecs) else begin
      bad++;
      $error("FAIL col_sel dut%0d k=%0d observed=%b expected=%b", d, k_m[d], cs, ecs);
    end
    total++;
    assert (ro === ero) else begin
      bad++;
      $error("FAIL row_out dut%0d k=%0d observed=%b expected=%b", d, k_m[d], ro, ero);
    end
    total++;
    assert (fd === efd) else begin
      bad++;
      $error("FAIL frame_done dut%0d k=%0d observed=%b expected=%b", d, k_m[d], fd, efd);
    end
  endtask

  // Advance n cycles, checking both instances at each falling edge
  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      check_dut(0, cs_a, ro_a, fd_a);
      check_dut(1, cs_b, ro_b, fd_b);
    end
  endtask

  function automatic logic [N*R-1:0] rand_image();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[N*R-1:0];
  endfunction

  initial begin
    // Reset, then idle with enable low
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(20);

    // Directed image: column 0 bottom row, column 4 top row
    image  = {7'b1000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000001};
    enable = 1'b1;
    cycles(12);

    // Change image mid-frame (column 2 on dut_a); visible next frame only
    image = rand_image();
    cycles(60);

    // Drop enable for a few cycles, then restart with a new image
    cycles(16);
    enable = 1'b0;
    cycles(3);
    image  = rand_image();
    enable = 1'b1;
    cycles(40);

    // Reset mid-scan with enable held high
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(40);

    // Randomized phase: image churn, occasional enable toggles and resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) image = rand_image();
      if ($urandom_range(0, 69) == 0) enable = ~enable;
      reset = ($urandom_range(0, 249) == 0);
      cycles(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
